// File: rtl/iobus_pkg.sv
// iobus_pkg: shared FSM state type and OTTER MMIO peripheral addresses for the IOBUS arbiter.
package iobus_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} iobus_state_t;
  localparam logic [31:0] SWITCHES_AD = 32'h11000000;
  localparam logic [31:0] LEDS_AD     = 32'h11000020;
  localparam logic [31:0] SSEG_AD     = 32'h11000040;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way round-robin picker.
//   req_i[1:0]  requests, bit n = master n
//   last_gnt_i  master granted most recently; loses a tie
//   gnt_valid_o any request present
//   gnt_id_o    winning master
module rr_arb2
  import iobus_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_gnt_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);
  assign gnt_valid_o = |req_i;
  assign gnt_id_o    = &req_i ? ~last_gnt_i : req_i[1];
endmodule

// File: rtl/iobus_arbiter.sv
// iobus_arbiter: round-robin sharing of the OTTER MMIO bus between the CPU (M0) and a second master (M1).
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   mX_req/wr/addr/wdata_i  request level, write flag, address, write data (sampled when granted)
//   mX_ack_o, mX_rdata_o    one-cycle completion pulse, read data valid with ack (0 for writes)
//   iobus_addr/out/wr_o     peripheral address, write data, one-cycle write strobe
//   iobus_in_i              peripheral read data, combinational on iobus_addr_o
//   busy_o                  transaction in progress
module iobus_arbiter
  import iobus_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              m0_req_i,
  input  logic              m0_wr_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_wr_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic [ADDR_W-1:0] iobus_addr_o,
  output logic [DATA_W-1:0] iobus_out_o,
  output logic              iobus_wr_o,
  input  logic [DATA_W-1:0] iobus_in_i,
  output logic              busy_o
);
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_wait_chk
    $error("WAIT_CYCLES must be 0..15");
  end

  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  iobus_state_t      state_q;
  logic [3:0]        wcnt_q;
  logic              gnt_q, last_gnt_q, wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              gnt_valid, gnt_id, access;

  rr_arb2 u_arb (
    .req_i      ({m1_req_i, m0_req_i}),
    .last_gnt_i (last_gnt_q),
    .gnt_valid_o(gnt_valid),
    .gnt_id_o   (gnt_id)
  );

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else
      case (state_q)
        IDLE: if (gnt_valid) begin
          state_q <= ACCESS;
          gnt_q   <= gnt_id;
          wr_q    <= gnt_id ? m1_wr_i : m0_wr_i;
          addr_q  <= gnt_id ? m1_addr_i : m0_addr_i;
          wdata_q <= gnt_id ? m1_wdata_i : m0_wdata_i;
          wcnt_q  <= WC;
        end
        ACCESS: if (wcnt_q != 4'd0) wcnt_q <= wcnt_q - 4'd1;
        else begin
          rdata_q <= wr_q ? '0 : iobus_in_i;
          state_q <= RESP;
        end
        RESP: begin
          last_gnt_q <= gnt_q;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

  // Bus and response outputs are decoded from registered state only, so
  // reset clears them immediately and the strobe is confined to the final ACCESS cycle.
  assign access       = state_q == ACCESS;
  assign iobus_addr_o = access ? addr_q : '0;
  assign iobus_out_o  = access ? wdata_q : '0;
  assign iobus_wr_o   = access && wcnt_q == 4'd0 && wr_q;
  assign busy_o       = state_q != IDLE;
  assign m0_ack_o     = state_q == RESP && !gnt_q;
  assign m1_ack_o     = state_q == RESP && gnt_q;
  assign m0_rdata_o   = m0_ack_o ? rdata_q : '0;
  assign m1_rdata_o   = m1_ack_o ? rdata_q : '0;
endmodule

// File: tb/tb_iobus_arbiter.sv
// tb_iobus_arbiter: directed and randomized checks of iobus_arbiter (WAIT_CYCLES 0 and 2) against a transaction-level model.
module tb_iobus_arbiter;
  import iobus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n [2];
  logic        req   [2][2];
  logic        wr    [2][2];
  logic [31:0] addr  [2][2];
  logic [31:0] wdata [2][2];
  logic        ack   [2][2];
  logic [31:0] rdata [2][2];
  logic [31:0] io_addr [2];
  logic [31:0] io_out  [2];
  logic        io_wr   [2];
  logic [31:0] io_in   [2];
  logic        busy    [2];

  int n_chk = 0, n_fail = 0;
  int k [2], mg [2], ml [2];
  logic        mwr [2];
  logic [31:0] ma [2], mw [2];

  always #5 clk = ~clk;

  function automatic logic [31:0] periph(logic [31:0] a);
    return (a == SWITCHES_AD) ? 32'h0000A5A5 : {a[15:0], ~a[31:16]};
  endfunction

  always_comb io_in[0] = periph(io_addr[0]);
  always_comb io_in[1] = periph(io_addr[1]);

  iobus_arbiter #(.WAIT_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n[0]),
    .m0_req_i(req[0][0]), .m0_wr_i(wr[0][0]), .m0_addr_i(addr[0][0]), .m0_wdata_i(wdata[0][0]),
    .m0_ack_o(ack[0][0]), .m0_rdata_o(rdata[0][0]),
    .m1_req_i(req[0][1]), .m1_wr_i(wr[0][1]), .m1_addr_i(addr[0][1]), .m1_wdata_i(wdata[0][1]),
    .m1_ack_o(ack[0][1]), .m1_rdata_o(rdata[0][1]),
    .iobus_addr_o(io_addr[0]), .iobus_out_o(io_out[0]), .iobus_wr_o(io_wr[0]),
    .iobus_in_i(io_in[0]), .busy_o(busy[0])
  );

  iobus_arbiter #(.WAIT_CYCLES(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n[1]),
    .m0_req_i(req[1][0]), .m0_wr_i(wr[1][0]), .m0_addr_i(addr[1][0]), .m0_wdata_i(wdata[1][0]),
    .m0_ack_o(ack[1][0]), .m0_rdata_o(rdata[1][0]),
    .m1_req_i(req[1][1]), .m1_wr_i(wr[1][1]), .m1_addr_i(addr[1][1]), .m1_wdata_i(wdata[1][1]),
    .m1_ack_o(ack[1][1]), .m1_rdata_o(rdata[1][1]),
    .iobus_addr_o(io_addr[1]), .iobus_out_o(io_out[1]), .iobus_wr_o(io_wr[1]),
    .iobus_in_i(io_in[1]), .busy_o(busy[1])
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wc(int d);
    return d == 1 ? 2 : 0;
  endfunction

  task automatic mdl_reset(int d);
    k[d] = 0; mg[d] = 0; ml[d] = 1; mwr[d] = 1'b0; ma[d] = '0; mw[d] = '0;
  endtask

  // A transaction occupies WAIT+3 cycles: idle sample, WAIT+1 bus cycles, one ack cycle.
  task automatic mdl_edge(int d);
    if (k[d] == 0) begin
      if (req[d][0] || req[d][1]) begin
        mg[d]  = (req[d][0] && req[d][1]) ? 1 - ml[d] : (req[d][1] ? 1 : 0);
        mwr[d] = wr[d][mg[d]];
        ma[d]  = addr[d][mg[d]];
        mw[d]  = wdata[d][mg[d]];
        k[d]   = 1;
      end
    end else if (k[d] == wc(d) + 2) begin
      ml[d] = mg[d];
      k[d]  = 0;
    end else k[d]++;
  endtask

  task automatic check_all(int d);
    int  w   = wc(d);
    bit  acc = k[d] > 0 && k[d] <= w + 1;
    bit  rsp = k[d] == w + 2;
    chk($sformatf("d%0d busy", d), 32'(busy[d]), 32'(k[d] != 0));
    chk($sformatf("d%0d iobus_addr", d), io_addr[d], acc ? ma[d] : 32'h0);
    chk($sformatf("d%0d iobus_out", d), io_out[d], acc ? mw[d] : 32'h0);
    chk($sformatf("d%0d iobus_wr", d), 32'(io_wr[d]), 32'(acc && k[d] == w + 1 && mwr[d]));
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("d%0d m%0d ack", d, m), 32'(ack[d][m]), 32'(rsp && mg[d] == m));
      chk($sformatf("d%0d m%0d rdata", d, m), rdata[d][m],
          (rsp && mg[d] == m && !mwr[d]) ? periph(ma[d]) : 32'h0);
    end
  endtask

  task automatic step(int d);
    @(posedge clk);
    if (rst_n[d]) mdl_edge(d);
    #1 check_all(d);
  endtask

  task automatic clear_in(int d);
    for (int m = 0; m < 2; m++) begin
      req[d][m] = 0; wr[d][m] = 0; addr[d][m] = '0; wdata[d][m] = '0;
    end
  endtask

  task automatic set_m(int d, int m, logic w, logic [31:0] a, logic [31:0] v);
    req[d][m] = 1; wr[d][m] = w; addr[d][m] = a; wdata[d][m] = v;
  endtask

  // Asserted and released between clock edges; outputs must clear without a clock.
  task automatic do_reset(int d);
    rst_n[d] = 1'b0;
    mdl_reset(d);
    #1;
    chk($sformatf("d%0d rst busy", d), 32'(busy[d]), 32'h0);
    chk($sformatf("d%0d rst wr", d), 32'(io_wr[d]), 32'h0);
    chk($sformatf("d%0d rst addr", d), io_addr[d], 32'h0);
    chk($sformatf("d%0d rst acks", d), 32'({ack[d][1], ack[d][0]}), 32'h0);
    check_all(d);
    #2 rst_n[d] = 1'b1;
  endtask

  task automatic rand_in(int d);
    for (int m = 0; m < 2; m++) begin
      case ($urandom_range(3))
        0: addr[d][m] = SWITCHES_AD;
        1: addr[d][m] = LEDS_AD;
        2: addr[d][m] = SSEG_AD;
        default: addr[d][m] = $urandom;
      endcase
      wdata[d][m] = $urandom;
      wr[d][m]    = 1'($urandom_range(1));
      if (k[d] == wc(d) + 2 && mg[d] == m) req[d][m] = ($urandom_range(2) == 0);
      else if (!req[d][m]) req[d][m] = ($urandom_range(2) == 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int ids[$], cyc[$];
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      clear_in(d);
      mdl_reset(d);
    end
    #1 check_all(0);
    check_all(1);
    #2 rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    set_m(0, 0, 1'b0, SWITCHES_AD, 32'h0);
    step(0);
    chk("t2 addr N+1", io_addr[0], SWITCHES_AD);
    step(0);
    chk("t2 m0 ack", 32'(ack[0][0]), 32'h1);
    chk("t2 m0 rdata", rdata[0][0], 32'h0000A5A5);
    chk("t2 m1 ack", 32'(ack[0][1]), 32'h0);
    req[0][0] = 0;
    step(0);

    set_m(0, 1, 1'b1, LEDS_AD, 32'h00001234);
    step(0);
    chk("t3 wr", 32'(io_wr[0]), 32'h1);
    chk("t3 addr", io_addr[0], LEDS_AD);
    chk("t3 data", io_out[0], 32'h00001234);
    step(0);
    chk("t3 wr one cycle", 32'(io_wr[0]), 32'h0);
    chk("t3 m1 ack", 32'(ack[0][1]), 32'h1);
    chk("t3 m1 rdata", rdata[0][1], 32'h0);
    req[0][1] = 0;
    step(0);

    set_m(0, 0, 1'b0, SSEG_AD, 32'h0);
    set_m(0, 1, 1'b0, SWITCHES_AD, 32'h0);
    do_reset(0);
    for (int i = 1; i <= 12; i++) begin
      step(0);
      if (ack[0][0] || ack[0][1]) begin
        ids.push_back(int'(ack[0][1]));
        cyc.push_back(i);
      end
    end
    chk("t4 ack count", ids.size(), 4);
    for (int j = 0; j < ids.size() && j < 4; j++) begin
      chk($sformatf("t4 grant %0d", j), ids[j], j % 2);
      if (j > 0) chk($sformatf("t4 gap %0d", j), cyc[j] - cyc[j-1], 3);
    end
    clear_in(0);
    repeat (4) step(0);

    do_reset(1);
    set_m(1, 0, 1'b1, LEDS_AD, 32'h0000CAFE);
    for (int i = 1; i <= 4; i++) begin
      step(1);
      chk($sformatf("t5 wr c%0d", i), 32'(io_wr[1]), 32'(i == 3));
      chk($sformatf("t5 addr c%0d", i), io_addr[1], i <= 3 ? LEDS_AD : 32'h0);
      chk($sformatf("t5 ack c%0d", i), 32'(ack[1][0]), 32'(i == 4));
    end
    req[1][0] = 0;
    step(1);

    set_m(1, 1, 1'b1, LEDS_AD, 32'h00000055);
    step(1);
    chk("t6 busy", 32'(busy[1]), 32'h1);
    set_m(1, 0, 1'b0, SWITCHES_AD, 32'h0);
    do_reset(1);
    for (int i = 1; i <= 4; i++) begin
      step(1);
      chk($sformatf("t6 no wr c%0d", i), 32'(io_wr[1]), 32'h0);
      chk($sformatf("t6 m1 ack c%0d", i), 32'(ack[1][1]), 32'h0);
      chk($sformatf("t6 m0 ack c%0d", i), 32'(ack[1][0]), 32'(i == 4));
    end
    chk("t6 m0 rdata", rdata[1][0], 32'h0000A5A5);
    req[1][0] = 0;
    repeat (6) step(1);
    clear_in(1);
    repeat (5) step(1);

    for (int d = 0; d < 2; d++) begin
      clear_in(d);
      do_reset(d);
      repeat (400) begin
        rand_in(d);
        step(d);
      end
      clear_in(d);
      repeat (6) step(d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
